// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and constants for the HI/LO multiply sequencer
package alu_pkg;

  localparam int HILO_W = 32;

  localparam logic [1:0] SGN_SS = 2'b00;
  localparam logic [1:0] SGN_SU = 2'b10;
  localparam logic [1:0] SGN_UU = 2'b11;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WAIT    = 2'd1,
    CAPTURE = 2'd2
  } state_t;

endpackage

// File: rtl/hilo_regs.sv
// rtl/hilo_regs.sv - HI/LO register pair; a product capture overrides move-to writes
module hilo_regs
  import alu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              capture,
  input  logic [HILO_W-1:0] cap_hi,
  input  logic [HILO_W-1:0] cap_lo,
  input  logic              mthi_en,
  input  logic              mtlo_en,
  input  logic [HILO_W-1:0] wdata,
  output logic [HILO_W-1:0] hi,
  output logic [HILO_W-1:0] lo
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi <= '0;
      lo <= '0;
    end else if (capture) begin
      hi <= cap_hi;
      lo <= cap_lo;
    end else begin
      if (mthi_en) hi <= wdata;
      if (mtlo_en) lo <= wdata;
    end
  end

endmodule

// File: rtl/mul_hilo_seq.sv
// rtl/mul_hilo_seq.sv - request handshake, latency sequencing and HI/LO capture
module mul_hilo_seq
  import alu_pkg::*;
#(
  parameter int MULT_LAT = 36,
  parameter int CNT_W    = 6
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [HILO_W-1:0] req_a,
  input  logic [HILO_W-1:0] req_b,
  input  logic [1:0]        req_sign,
  output logic [HILO_W-1:0] mul_a,
  output logic [HILO_W-1:0] mul_b,
  output logic [4:0]        mul_ctrl,
  input  logic [HILO_W-1:0] mul_lower,
  input  logic [HILO_W-1:0] mul_higher,
  input  logic              mthi_en,
  input  logic              mtlo_en,
  input  logic [HILO_W-1:0] wdata,
  output logic [HILO_W-1:0] hi,
  output logic [HILO_W-1:0] lo,
  output logic              busy,
  output logic              done
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MULT_LAT - 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;

  // Operands are only loaded in IDLE so the multiplier never sees a change mid-flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mul_a    <= '0;
      mul_b    <= '0;
      mul_ctrl <= '0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            mul_a    <= req_a;
            mul_b    <= req_b;
            mul_ctrl <= {3'b000, req_sign};
            cnt      <= '0;
            state    <= WAIT;
          end
        end
        WAIT: begin
          if (cnt == CNT_LAST) state <= CAPTURE;
          else                 cnt   <= cnt + 1'b1;
        end
        CAPTURE: begin
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign req_ready = (state == IDLE);
  assign busy      = (state != IDLE);

  hilo_regs u_hilo_regs (
    .clk     (clk),
    .rst_n   (rst_n),
    .capture (state == CAPTURE),
    .cap_hi  (mul_higher),
    .cap_lo  (mul_lower),
    .mthi_en (mthi_en),
    .mtlo_en (mtlo_en),
    .wdata   (wdata),
    .hi      (hi),
    .lo      (lo)
  );

endmodule
